// File: rtl/cic_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : cic_sample_uart_tx
// Description : Captures each decimated CIC sample on a rising edge of the
//               decimator strobe and sends it off-chip as a UART 8N1 frame
//               with payload {marker, sample}. A one-deep pending buffer
//               absorbs one sample that arrives mid-frame; further samples
//               while it is full are dropped and flagged as overrun.
// Ports       : clk             - system clock
//               rst             - asynchronous active-high reset
//               sample_strobe_i - decimator strobe (sampled as data)
//               sample_data_i   - decimated sample
//               overrun_clr_i   - synchronous clear of sticky overrun
//               tx_o            - UART line, idles high, registered
//               busy_o          - frame in flight or sample pending
//               overrun_o       - sticky sample-drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module cic_sample_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SAMPLE_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_strobe_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_data_i,
  input  logic                    overrun_clr_i,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                FRAME_W   = SAMPLE_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Strobe synchronizer; reset high so a strobe held across reset is not an edge.
  logic s1_q, s2_q, prev_q;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [FRAME_W-1:0]      shreg_q, shreg_d;
  logic [SAMPLE_WIDTH-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    marker_q, marker_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;

  logic                    edge_w;
  logic                    wrap_w;
  logic                    load_w;
  logic                    edge_used_w;
  logic                    ovr_set_w;
  logic [SAMPLE_WIDTH-1:0] load_val_w;

  assign edge_w = s2_q & ~prev_q;
  assign wrap_w = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    marker_d    = marker_q;
    load_w      = 1'b0;
    load_val_w  = pend_q;
    edge_used_w = 1'b0;
    ovr_set_w   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (edge_w) begin
          load_w      = 1'b1;
          load_val_w  = sample_data_i;
          edge_used_w = 1'b1;
        end
      end
      ST_START: begin
        if (wrap_w) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (wrap_w) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (wrap_w) begin
          baud_d = '0;
          if (pend_vld_q) begin
            // Pending sample goes out next; a coinciding capture refills pending.
            load_w      = 1'b1;
            load_val_w  = pend_q;
            edge_used_w = edge_w;
            pend_vld_d  = edge_w;
            if (edge_w) pend_d = sample_data_i;
          end else if (edge_w) begin
            load_w      = 1'b1;
            load_val_w  = sample_data_i;
            edge_used_w = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture that could not go straight to the shifter.
    if (edge_w && !edge_used_w) begin
      if (!pend_vld_q) begin
        pend_d     = sample_data_i;
        pend_vld_d = 1'b1;
      end else begin
        ovr_set_w = 1'b1;
      end
    end

    if (load_w) begin
      state_d  = ST_START;
      baud_d   = '0;
      bit_d    = '0;
      shreg_d  = {marker_q, load_val_w};
      marker_d = ~marker_q;
    end

    ovr_d = ovr_set_w | (ovr_q & ~overrun_clr_i);

    // Line level is derived from the next state so tx is a clean flop output.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE) | pend_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      marker_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      s1_q       <= sample_strobe_i;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      marker_q   <= marker_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_sample_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_sample_uart_tx
// Description : Self-checking bench for cic_sample_uart_tx. A frame-level
//               reference model (frame start time, payload, pending queue)
//               predicts tx/busy/overrun every clock; directed scenarios are
//               followed by randomized strobe traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_sample_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic [6:0] data = 7'h00;
  logic       clr = 1'b0;
  logic       tx, busy, overrun;

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cic_sample_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SAMPLE_WIDTH(7)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_strobe_i(strobe),
    .sample_data_i  (data),
    .overrun_clr_i  (clr),
    .tx_o           (tx),
    .busy_o         (busy),
    .overrun_o      (overrun)
  );

  // ---------------- reference model ----------------
  int         n;          // clock edges since reset
  logic [2:0] sh;         // strobe as sampled at edges n-1, n-2, n-3
  bit         active;     // a frame is on the line
  int         fstart;     // edge after which the frame's start bit begins
  logic [7:0] payload;
  logic [6:0] pendq[$];
  bit         marker;
  bit         m_ovr;

  function automatic void model_reset();
    n      = 0;
    sh     = 3'b111;
    active = 0;
    fstart = 0;
    payload = '0;
    pendq.delete();
    marker = 0;
    m_ovr  = 0;
  endfunction

  function automatic void start_frame(input logic [6:0] p);
    active  = 1;
    fstart  = n;
    payload = {marker, p};
    marker  = ~marker;
  endfunction

  function automatic void model_step(input logic st, input logic [6:0] d, input logic c);
    bit cap;
    bit ended;
    bit ovr_set;
    logic [6:0] p;
    n++;
    cap = sh[1] & ~sh[2];
    sh  = {sh[1:0], st};
    ovr_set = 0;
    ended = active && ((n - fstart) == 10 * CPB);
    if (ended) active = 0;
    if (!active) begin
      if (pendq.size() > 0) begin
        p = pendq.pop_front();
        start_frame(p);
        if (cap) pendq.push_back(d);
      end else if (cap) begin
        start_frame(d);
      end
    end else if (cap) begin
      if (pendq.size() == 0) pendq.push_back(d);
      else ovr_set = 1;
    end
    m_ovr = ovr_set | (m_ovr & ~c);
  endfunction

  function automatic logic exp_tx();
    int k;
    if (!active) return 1'b1;
    k = (n - fstart) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return payload[k-1];
  endfunction

  function automatic logic exp_busy();
    return active || (pendq.size() != 0);
  endfunction

  // ---------------- checking / stimulus helpers ----------------
  task automatic check(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d, t=%0t)", tag, obs, expv, n, $time);
    end
  endtask

  task automatic tick();
    logic st, c, r;
    logic [6:0] d;
    st = strobe;
    d  = data;
    c  = clr;
    r  = rst;
    @(posedge clk);
    #1;
    if (r || rst) model_reset();
    else model_step(st, d, c);
    check("tx", tx, exp_tx());
    check("busy", busy, exp_busy());
    check("overrun", overrun, m_ovr);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic pulse(input logic [6:0] d, input int hi, input int lo, input int clr_at);
    data   = d;
    strobe = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      clr = (i == clr_at);
      tick();
    end
    clr    = 1'b0;
    strobe = 1'b0;
    idle(lo);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  hi, lo, ca;
    bit  reached;
    model_reset();

    // Reset state
    idle(3);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    idle(5);

    // Single 7'h55 frame
    pulse(7'h55, 3, 60, 0);

    // Two frames 60 cycles apart, markers 0 then 1
    apply_reset();
    pulse(7'h01, 3, 57, 0);
    pulse(7'h7F, 3, 60, 0);

    // Second strobe 10 cycles after first: back-to-back frames
    apply_reset();
    pulse(7'h12, 3, 7, 0);
    pulse(7'h34, 3, 90, 0);

    // Three strobes in one frame: third dropped, then clear, then clear vs drop
    apply_reset();
    pulse(7'h0A, 3, 3, 0);
    pulse(7'h0B, 3, 3, 0);
    pulse(7'h0C, 3, 90, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle(3);
    pulse(7'h21, 3, 3, 0);
    pulse(7'h22, 3, 3, 0);
    pulse(7'h23, 4, 90, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    idle(3);

    // Strobe held high across reset release
    rst    = 1'b1;
    strobe = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(10);
    strobe = 1'b0;
    idle(3);
    pulse(7'h2A, 3, 50, 0);

    // Reset asserted during data bit 3
    apply_reset();
    pulse(7'h3C, 3, 0, 0);
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (active && (n - fstart) == 4 * CPB + 1) reached = 1;
      else tick();
    end
    check("reach_data_bit3", reached, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("midframe_rst_tx", tx, 1'b1);
    check("midframe_rst_busy", busy, 1'b0);
    idle(2);
    rst = 1'b0;
    idle(3);
    pulse(7'h3C, 3, 50, 0);

    // Randomized strobe traffic
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      hi = $urandom_range(2, 5);
      lo = $urandom_range(2, 60);
      ca = ($urandom_range(0, 7) == 0) ? $urandom_range(1, hi) : 0;
      pulse(7'($urandom), hi, lo, ca);
    end
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
